// File: rtl/shift_seq.sv
// Multi-cycle RV32I shifter (SLL/SRL/SRA) that walks a working register by up to STEP bits per cycle.
// Define SHIFT_SEQ_B2B_EN to let DONE accept the next request in the same edge as the response handshake.
module shift_seq #(
  parameter  int XLEN = 32,
  parameter  int STEP = 4,
  localparam int SW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_data,
  input  logic [SW-1:0]   req_shamt,
  input  logic [1:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One bit wider than the shift amount so STEP == XLEN still compares correctly.
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

  state_t          state_r;
  logic [XLEN-1:0] work_r;
  logic [SW-1:0]   remaining_r;
  logic [1:0]      op_r;
  logic            rsp_valid_r;
  logic            busy_r;

  logic [SW:0]     step_s;
  logic [XLEN-1:0] shifted_s;
  logic [SW-1:0]   rem_next_s;
  logic            req_ready_s;
  logic            accept_s;

  // Step size for this cycle: the smaller of what is left and STEP.
  always_comb begin
    step_s = STEP_W;
    if ({1'b0, remaining_r} < STEP_W) begin
      step_s = {1'b0, remaining_r};
    end else begin
      step_s = STEP_W;
    end
  end

  // One narrow shift step of the working register; op 10 falls through to SLL.
  always_comb begin
    shifted_s = work_r;
    case (op_r)
      2'b01:   shifted_s = work_r >> step_s;
      2'b11:   shifted_s = XLEN'($signed(work_r) >>> step_s);
      default: shifted_s = work_r << step_s;
    endcase
  end

  // Remaining count after this step; step never exceeds remaining, so no underflow.
  always_comb begin
    rem_next_s = remaining_r - step_s[SW-1:0];
  end

  // Request acceptance depends only on state (and rsp_ready in the back-to-back build).
  always_comb begin
    req_ready_s = 1'b0;
    if (rst) begin
      req_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    req_ready_s = 1'b1;
`ifdef SHIFT_SEQ_B2B_EN
        DONE:    req_ready_s = rsp_ready;
`else
        DONE:    req_ready_s = 1'b0;
`endif
        default: req_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = req_valid && req_ready_s;

  // Sequencer state, working register and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      work_r      <= {XLEN{1'b0}};
      remaining_r <= {SW{1'b0}};
      op_r        <= 2'b00;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            work_r      <= req_data;
            remaining_r <= req_shamt;
            op_r        <= req_op;
            busy_r      <= 1'b1;
            if (req_shamt == {SW{1'b0}}) begin
              state_r     <= DONE;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r     <= SHIFT;
              rsp_valid_r <= 1'b0;
            end
          end else begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        SHIFT: begin
          work_r      <= shifted_s;
          remaining_r <= rem_next_s;
          busy_r      <= 1'b1;
          if (rem_next_s == {SW{1'b0}}) begin
            state_r     <= DONE;
            rsp_valid_r <= 1'b1;
          end else begin
            state_r     <= SHIFT;
            rsp_valid_r <= 1'b0;
          end
        end
        DONE: begin
          // accept_s can only be set here in the back-to-back build.
          if (rsp_ready && accept_s) begin
            work_r      <= req_data;
            remaining_r <= req_shamt;
            op_r        <= req_op;
            busy_r      <= 1'b1;
            if (req_shamt == {SW{1'b0}}) begin
              state_r     <= DONE;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r     <= SHIFT;
              rsp_valid_r <= 1'b0;
            end
          end else if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r     <= DONE;
            rsp_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = work_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_shift_seq.sv
// Directed and random self-checking bench for shift_seq (XLEN=32, STEP=4).
module tb_shift_seq;

  localparam int N_RAND = 1000;
`ifdef SHIFT_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = 32'd0;
  logic [4:0]  req_shamt = 5'd0;
  logic [1:0]  req_op = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  int          rx_cnt;
  bit          stream_done;

  shift_seq #(.XLEN(32), .STEP(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_shamt(req_shamt), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    case (o)
      2'b01:   return d >> s;
      2'b11:   return 32'($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    end
    rst = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_sll_latency();
    @(negedge clk);
    req_valid = 1'b1; req_data = 32'h0000_0001; req_shamt = 5'd31; req_op = 2'b00; rsp_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid = 1'b0; req_data = 32'hFFFF_FFFF; req_op = 2'b11; end
      total_cnt++; if (busy !== (k <= 9)) $display("FAIL sll_busy k=%0d got=%b exp=%b", k, busy, k <= 9); else pass_cnt++;
      total_cnt++; if (rsp_valid !== (k == 9)) $display("FAIL sll_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, k == 9); else pass_cnt++;
      total_cnt++; if (req_ready !== (k == 10)) $display("FAIL sll_req_ready k=%0d got=%b exp=%b", k, req_ready, k == 10); else pass_cnt++;
      if (k == 9) begin
        total_cnt++; if (rsp_data !== 32'h8000_0000) $display("FAIL sll_data got=%h exp=80000000", rsp_data); else pass_cnt++;
      end
    end
  endtask

  task automatic test_fill();
    logic [1:0]  ops [2] = '{2'b11, 2'b01};
    logic [31:0] exps[2] = '{32'hFC00_0007, 32'h0400_0007};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req_valid = 1'b1; req_data = 32'h8000_00F0; req_shamt = 5'd5; req_op = ops[v]; rsp_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) begin req_valid = 1'b0; req_shamt = 5'd0; end
        total_cnt++; if (rsp_valid !== (k == 3)) $display("FAIL fill_rsp_valid op=%b k=%0d got=%b exp=%b", ops[v], k, rsp_valid, k == 3); else pass_cnt++;
        if (k == 3) begin
          total_cnt++; if (rsp_data !== exps[v]) $display("FAIL fill_data op=%b got=%h exp=%h", ops[v], rsp_data, exps[v]); else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_zero_backpressure();
    @(negedge clk);
    req_valid = 1'b1; req_data = 32'h1234_5678; req_shamt = 5'd0; req_op = 2'b00; rsp_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin req_data = 32'hDEAD_BEEF; req_shamt = 5'd7; end
      if (k <= 5) begin
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid k=%0d got=%b exp=1", k, rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_data !== 32'h1234_5678) $display("FAIL bp_data k=%0d got=%h exp=12345678", k, rsp_data); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready k=%0d got=%b exp=0", k, req_ready); else pass_cnt++;
      end else begin
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL bp_release_busy got=%b exp=0", busy); else pass_cnt++;
      end
      if (k == 5) begin req_valid = 1'b0; rsp_ready = 1'b1; end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_data = 32'h0000_ABCD; req_shamt = 5'd20; req_op = 2'b01; rsp_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_rsp_valid k=%0d got=%b exp=0", k, rsp_valid); else pass_cnt++;
      total_cnt++; if (busy !== (k <= 2)) $display("FAIL rstmid_busy k=%0d got=%b exp=%b", k, busy, k <= 2); else pass_cnt++;
      if (k == 2 || k == 3) begin
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rstmid_req_ready k=%0d got=%b exp=0", k, req_ready); else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++; if (rsp_data !== 32'd0) $display("FAIL rstmid_data got=%h exp=0", rsp_data); else pass_cnt++;
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_data = 32'h0000_0003; req_shamt = 5'd1; req_op = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      total_cnt++; if (rsp_valid !== (k == 2)) $display("FAIL rstmid_next_valid k=%0d got=%b exp=%b", k, rsp_valid, k == 2); else pass_cnt++;
      if (k == 2) begin
        total_cnt++; if (rsp_data !== 32'h0000_0006) $display("FAIL rstmid_next_data got=%h exp=6", rsp_data); else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    int sent = 0;
    int got = 0;
    int exp_c;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp_c = B2B ? got + 1 : 2 * got + 1;
        total_cnt++; if (rsp_data !== vals[got]) $display("FAIL b2b_data i=%0d got=%h exp=%h", got, rsp_data, vals[got]); else pass_cnt++;
        total_cnt++; if (c !== exp_c) $display("FAIL b2b_cycle i=%0d got=%0d exp=%0d", got, c, exp_c); else pass_cnt++;
        got++;
      end
      if (sent < 4) begin
        req_valid = 1'b1; req_data = vals[sent]; req_shamt = 5'd0; req_op = 2'b00;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (req_valid && req_ready) sent++;
    end
    total_cnt++; if (got !== 4) $display("FAIL b2b_count got=%0d exp=4", got); else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_random_stream();
    rx_cnt = 0;
    stream_done = 1'b0;
    exp_q.delete();
    fork
      begin : producer
        int sent = 0;
        bit pending = 1'b0;
        logic [31:0] d;
        logic [4:0] s;
        logic [1:0] o;
        while (sent < N_RAND && !stream_done) begin
          @(negedge clk);
          if (!pending) begin
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            o = 2'($urandom_range(0, 3));
            pending = 1'b1;
          end
          req_valid = ($urandom_range(0, 4) != 0);
          req_data = d; req_shamt = s; req_op = o;
          #1;
          if (req_valid && req_ready) begin
            exp_q.push_back(ref_shift(d, s, o));
            pending = 1'b0;
            sent++;
          end
        end
        @(negedge clk);
        req_valid = 1'b0;
      end
      begin : consumer
        logic [31:0] e;
        for (int c = 0; c < 30000 && rx_cnt < N_RAND; c++) begin
          @(negedge clk);
          rsp_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (rsp_valid && rsp_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
              $display("FAIL rand_unexpected_rsp i=%0d got=%h exp=none", rx_cnt, rsp_data);
            end else begin
              e = exp_q.pop_front();
              if (rsp_data !== e) $display("FAIL rand_data i=%0d got=%h exp=%h", rx_cnt, rsp_data, e);
              else pass_cnt++;
            end
            rx_cnt++;
          end
        end
        stream_done = 1'b1;
      end
    join
    total_cnt++; if (rx_cnt !== N_RAND) $display("FAIL rand_count got=%0d exp=%0d", rx_cnt, N_RAND); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sll_latency();
    test_fill();
    test_zero_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
